noc_traffic_node: RTL

NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

---
 rtl/noc_traffic_node.sv | 129 ++++++++++++
 1 files changed

// File: rtl/noc_traffic_node.sv
// Traffic-generating NoC endpoint: injects PKT_LIMIT packets using a selectable
// destination pattern and counts/validates packets arriving from the network.
module noc_traffic_node #(
  parameter int ADDRESS    = 0,
  parameter int NUM_PE     = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_PE),
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LIMIT  = 100,
  parameter int PATTERN    = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_tx_data,
  output logic                             o_tx_valid,
  input  logic                             i_tx_ready,
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] i_rx_data,
  input  logic                             i_rx_valid,
  output logic                             o_rx_ready,
  input  logic                             i_stop,
  output logic                             o_tx_done,
  output logic [31:0]                      o_tx_count,
  output logic [31:0]                      o_rx_count,
  output logic                             o_rx_error
);

  localparam int TOTAL = DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned NPE    = NUM_PE;
  localparam int unsigned SELF_U = ADDRESS;
  localparam logic [ADDR_WIDTH-1:0] SELF  = ADDR_WIDTH'(ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] NEIGH = ADDR_WIDTH'((ADDRESS + 1) % NUM_PE);
  localparam logic [ADDR_WIDTH-1:0] COMP  = ADDR_WIDTH'(NUM_PE - 1 - ADDRESS);
  localparam logic [31:0] LIMIT    = 32'(PKT_LIMIT);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [15:0] SEED     = 16'(ADDRESS + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t                  state, state_nx;
  logic [31:0]             tx_count;
  logic [31:0]             gap_cnt;
  logic [31:0]             rx_count;
  logic [15:0]             lfsr;
  logic                    stop_pend;
  logic                    rx_error;
  logic                    xfer;
  logic                    rx_fire;
  logic [ADDR_WIDTH-1:0]   dest;
  logic [TOTAL-1:0]        pkt;
  int unsigned             rnd;
  logic                    unused_rx_bits;

  assign o_tx_valid = (state == SEND);
  assign o_tx_done  = (state == DONE);
  assign o_rx_ready = i_reset_n;
  assign xfer       = o_tx_valid & i_tx_ready;
  assign rx_fire    = i_rx_valid & o_rx_ready;
  assign o_tx_count = tx_count;
  assign o_rx_count = rx_count;
  assign o_rx_error = rx_error;
  assign unused_rx_bits = ^i_rx_data[DATA_WIDTH-1:0];

  always_comb begin
    rnd = 32'(lfsr[ADDR_WIDTH-1:0]) % NPE;
    if (rnd == SELF_U) rnd = (rnd + 1) % NPE;
    if (PATTERN == 0)      dest = NEIGH;
    else if (PATTERN == 1) dest = COMP;
    else                   dest = ADDR_WIDTH'(rnd);
  end

  // The LFSR only moves on a transfer, so the presented packet is stable while stalled.
  always_comb begin
    pkt = '0;
    pkt[TOTAL-1:DATA_WIDTH]         = dest;
    pkt[DATA_WIDTH-1 -: ADDR_WIDTH] = SELF;
    pkt[15:0]                       = tx_count[15:0];
    o_tx_data = o_tx_valid ? pkt : '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (LIMIT == '0 || i_stop) ? DONE : SEND;
      SEND: begin
        if (i_tx_ready) begin
          if (tx_count + 32'd1 == LIMIT || i_stop || stop_pend) state_nx = DONE;
          else if (GAP_CYCLES > 0)                              state_nx = GAP;
          else                                                  state_nx = SEND;
        end
      end
      GAP: begin
        if (i_stop)                   state_nx = DONE;
        else if (gap_cnt == GAP_LAST) state_nx = SEND;
      end
      default: state_nx = DONE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      tx_count  <= '0;
      gap_cnt   <= '0;
      lfsr      <= SEED;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        tx_count <= tx_count + 32'd1;
        lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      if (state == GAP && state_nx == GAP) gap_cnt <= gap_cnt + 32'd1;
      else                                 gap_cnt <= '0;
      // Remember a stop seen while a packet is still waiting for ready.
      if (state == SEND && i_stop) stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_count <= '0;
      rx_error <= 1'b0;
    end else if (rx_fire) begin
      if (rx_count != '1) rx_count <= rx_count + 32'd1;
      if (i_rx_data[TOTAL-1:DATA_WIDTH] != SELF) rx_error <= 1'b1;
    end
  end

endmodule
